// File: rtl/fpu_out_pkg.sv
// -----------------------------------------------------------------------------
// fpu_out_pkg
// Shared constants for the FPU result-output arbiter.
//   - Pipe indices, used as bit positions of the one-hot grant vector.
//   - Credit counter width. It matches the 3-bit credit_cnt port, which
//     holds CREDITS values up to 7.
//   - ctr_width(), which sizes a counter to hold 0..max_val.
// -----------------------------------------------------------------------------
package fpu_out_pkg;

   localparam int NUM_PIPES = 3;
   localparam int PIPE_ADD  = 0;
   localparam int PIPE_MUL  = 1;
   localparam int PIPE_DIV  = 2;

   localparam int CREDIT_W  = 3;

   // Returns the number of bits needed to hold every value from 0 to max_val.
   function automatic int ctr_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage : fpu_out_pkg

// File: rtl/fpu_out_age_ctr.sv
// -----------------------------------------------------------------------------
// fpu_out_age_ctr
// Saturating age counter for one result pipe. It counts consecutive cycles
// in which the pipe requests but loses arbitration. It saturates at
// STARVE_MAX and clears when the pipe is granted or stops requesting.
// Ports:
//   rclk      clock
//   arst      asynchronous active-high reset; clears the age
//   req_i     pipe has a result pending
//   grant_i   pipe won arbitration this cycle
//   starved_o age has reached STARVE_MAX; the pipe goes to top priority
// -----------------------------------------------------------------------------
module fpu_out_age_ctr
#(
   parameter int STARVE_MAX = 4,
   parameter int AGE_W      = 3
)
(
   input  logic rclk,
   input  logic arst,
   input  logic req_i,
   input  logic grant_i,
   output logic starved_o
);

   localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(STARVE_MAX);

   logic [AGE_W-1:0] age_q;
   logic [AGE_W-1:0] age_d;

   // NOTE: every signal driven from always_comb is assigned a default first,
   // so no path through the block leaves it unassigned and no latch is inferred.
   always_comb begin
      age_d = age_q;
      if (!req_i || grant_i) begin
         age_d = '0;
      end else if (age_q != AGE_MAX) begin
         age_d = age_q + 1'b1;
      end
   end

   // NOTE: state registers use non-blocking assignments. All flops then
   // sample their inputs before any flop updates, whatever order the
   // simulator evaluates the blocks in.
   always_ff @(posedge rclk or posedge arst) begin
      if (arst) begin
         age_q <= '0;
      end else begin
         age_q <= age_d;
      end
   end

   assign starved_o = (age_q == AGE_MAX);

endmodule : fpu_out_age_ctr

// File: rtl/fpu_out_arb.sv
// -----------------------------------------------------------------------------
// fpu_out_arb
// Result-output arbiter in front of the FPU output datapath. Each cycle it
// grants at most one of the div/mul/add pipes, provided a CPX credit is
// available. Losing pipes are stalled.
// Priority:
//   - A requesting pipe whose age has reached STARVE_MAX wins first.
//     Among starved pipes, add > mul > div.
//   - Otherwise the fixed order is div > mul > add.
// Ports:
//   rclk, arst               clock, asynchronous active-high reset
//   {div,mul,add}_req        pipe has a result ready
//   {div,mul,add}_thread     thread ID of that result
//   cpx_fp_credit_ret        one-cycle pulse; CPX freed one packet slot
//   dest_rdy                 one-hot grant: [2] div, [1] mul, [0] add
//   req_thread               thread of the granted pipe, 0 when no grant
//   {div,mul,add}_out_stall  pipe must hold its result
//   fp_cpx_req_cq            registered |dest_rdy, aligned with the packet flop
//   credit_cnt               available credits
//   credit_err               sticky: credit returned with counter already full
// -----------------------------------------------------------------------------
module fpu_out_arb
   import fpu_out_pkg::*;
#(
   parameter int CREDITS    = 2,
   parameter int STARVE_MAX = 4
)
(
   input  logic                rclk,
   input  logic                arst,
   input  logic                div_req,
   input  logic [1:0]          div_thread,
   input  logic                mul_req,
   input  logic [1:0]          mul_thread,
   input  logic                add_req,
   input  logic [1:0]          add_thread,
   input  logic                cpx_fp_credit_ret,
   output logic [2:0]          dest_rdy,
   output logic [1:0]          req_thread,
   output logic                div_out_stall,
   output logic                mul_out_stall,
   output logic                add_out_stall,
   output logic                fp_cpx_req_cq,
   output logic [CREDIT_W-1:0] credit_cnt,
   output logic                credit_err
);

   localparam int                AGE_W    = ctr_width(STARVE_MAX);
   localparam logic [CREDIT_W-1:0] CRED_MAX = CREDIT_W'(CREDITS);

   logic [NUM_PIPES-1:0] req;
   logic [NUM_PIPES-1:0] starved;
   logic [NUM_PIPES-1:0] starve_req;
   logic [NUM_PIPES-1:0] grant;
   logic                 can_send;
   logic                 granted;

   logic [CREDIT_W-1:0]  cnt_q, cnt_d;
   logic                 err_q, err_d;
   logic                 cq_q,  cq_d;

   assign req = {div_req, mul_req, add_req};

   for (genvar p = 0; p < NUM_PIPES; p++) begin : g_age
      fpu_out_age_ctr #(
         .STARVE_MAX (STARVE_MAX),
         .AGE_W      (AGE_W)
      ) u_age (
         .rclk      (rclk),
         .arst      (arst),
         .req_i     (req[p]),
         .grant_i   (grant[p]),
         .starved_o (starved[p])
      );
   end

   // The registered credit count is used as-is; a credit returned this cycle
   // only counts from the next cycle. Gating with arst keeps the grant at
   // zero while reset is held. Without it, the counter resetting to CREDITS
   // would raise a grant during reset.
   assign can_send   = (cnt_q != '0) && !arst;
   assign starve_req = req & starved;

   always_comb begin
      grant = '0;
      if (can_send) begin
         if      (starve_req[PIPE_ADD]) grant[PIPE_ADD] = 1'b1;
         else if (starve_req[PIPE_MUL]) grant[PIPE_MUL] = 1'b1;
         else if (starve_req[PIPE_DIV]) grant[PIPE_DIV] = 1'b1;
         else if (req[PIPE_DIV])        grant[PIPE_DIV] = 1'b1;
         else if (req[PIPE_MUL])        grant[PIPE_MUL] = 1'b1;
         else if (req[PIPE_ADD])        grant[PIPE_ADD] = 1'b1;
      end
   end

   assign granted  = |grant;
   assign dest_rdy = grant;

   always_comb begin
      req_thread = 2'b00;
      if      (grant[PIPE_DIV]) req_thread = div_thread;
      else if (grant[PIPE_MUL]) req_thread = mul_thread;
      else if (grant[PIPE_ADD]) req_thread = add_thread;
   end

   assign div_out_stall = div_req & ~grant[PIPE_DIV];
   assign mul_out_stall = mul_req & ~grant[PIPE_MUL];
   assign add_out_stall = add_req & ~grant[PIPE_ADD];

   // A grant and a return in the same cycle cancel each other. A return with
   // no grant while the counter is full would overflow it. In that case the
   // counter holds and the error is flagged instead.
   always_comb begin
      cnt_d = cnt_q;
      err_d = err_q;
      cq_d  = granted;
      if (granted && !cpx_fp_credit_ret) begin
         cnt_d = cnt_q - 1'b1;
      end else if (!granted && cpx_fp_credit_ret) begin
         if (cnt_q == CRED_MAX) begin
            err_d = 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge rclk or posedge arst) begin
      if (arst) begin
         cnt_q <= CRED_MAX;
         err_q <= 1'b0;
         cq_q  <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
         cq_q  <= cq_d;
      end
   end

   assign credit_cnt    = cnt_q;
   assign credit_err    = err_q;
   assign fp_cpx_req_cq = cq_q;

endmodule : fpu_out_arb

// File: tb/tb_fpu_out_arb.sv
// -----------------------------------------------------------------------------
// tb_fpu_out_arb
// Self-checking bench for fpu_out_arb with CREDITS = 2 and STARVE_MAX = 4.
// It covers:
//   - directed vectors from a table
//   - hand-written starvation and mid-operation reset sequences
//   - randomized traffic checked against a behavioural model
// -----------------------------------------------------------------------------
module tb_fpu_out_arb;

   localparam int CREDITS    = 2;
   localparam int STARVE_MAX = 4;

   logic       rclk = 1'b0;
   logic       arst = 1'b0;
   logic       div_req = 1'b0, mul_req = 1'b0, add_req = 1'b0;
   logic [1:0] div_thread = '0, mul_thread = '0, add_thread = '0;
   logic       cpx_fp_credit_ret = 1'b0;
   logic [2:0] dest_rdy;
   logic [1:0] req_thread;
   logic       div_out_stall, mul_out_stall, add_out_stall;
   logic       fp_cpx_req_cq;
   logic [2:0] credit_cnt;
   logic       credit_err;

   int n_checks = 0;
   int n_fail   = 0;

   fpu_out_arb #(
      .CREDITS    (CREDITS),
      .STARVE_MAX (STARVE_MAX)
   ) dut (
      .rclk              (rclk),
      .arst              (arst),
      .div_req           (div_req),
      .div_thread        (div_thread),
      .mul_req           (mul_req),
      .mul_thread        (mul_thread),
      .add_req           (add_req),
      .add_thread        (add_thread),
      .cpx_fp_credit_ret (cpx_fp_credit_ret),
      .dest_rdy          (dest_rdy),
      .req_thread        (req_thread),
      .div_out_stall     (div_out_stall),
      .mul_out_stall     (mul_out_stall),
      .add_out_stall     (add_out_stall),
      .fp_cpx_req_cq     (fp_cpx_req_cq),
      .credit_cnt        (credit_cnt),
      .credit_err        (credit_err)
   );

   always #5 rclk = ~rclk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Vector layout: req = {div,mul,add}; thr = {div,mul,add} threads.
   typedef struct {
      logic [2:0] req;
      logic [5:0] thr;
      logic       ret;
      logic [2:0] dest;
      logic [1:0] rthr;
      logic [2:0] stall;
      logic [2:0] cnt;
      logic       cq;
      logic       err;
   } vec_t;

   vec_t tbl [10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic set_in(input logic [2:0] req, input logic [5:0] thr, input logic ret);
      {div_req, mul_req, add_req}          = req;
      {div_thread, mul_thread, add_thread} = thr;
      cpx_fp_credit_ret                    = ret;
   endtask

   function automatic logic [2:0] stalls();
      return {div_out_stall, mul_out_stall, add_out_stall};
   endfunction

   // Returns just after a rising edge, with state at reset values.
   task automatic do_reset();
      @(posedge rclk);
      #1;
      arst = 1'b1;
      set_in(3'b000, 6'b0, 1'b0);
      #2;
      arst = 1'b0;
   endtask

   // Reference model. Pipe index 0 = add, 1 = mul, 2 = div.
   int m_age [3];
   int m_cnt;
   bit m_err;

   function automatic int model_pick(input logic [2:0] req);
      if (m_cnt == 0) return -1;
      for (int p = 0; p < 3; p++)
         if (req[p] && m_age[p] == STARVE_MAX) return p;
      for (int p = 2; p >= 0; p--)
         if (req[p]) return p;
      return -1;
   endfunction

   task automatic model_step(input logic [2:0] req, input int g, input logic ret);
      for (int p = 0; p < 3; p++) begin
         if (!req[p] || p == g) m_age[p] = 0;
         else if (m_age[p] < STARVE_MAX) m_age[p] = m_age[p] + 1;
      end
      m_cnt = m_cnt - ((g >= 0) ? 1 : 0) + (ret ? 1 : 0);
      if (m_cnt > CREDITS) begin
         m_cnt = CREDITS;
         m_err = 1'b1;
      end
   endtask

   initial begin
      logic [2:0] r_req;
      logic [5:0] r_thr;
      logic       r_ret;
      logic [2:0] hold;
      logic [2:0] exp_dest;
      logic [1:0] exp_thr;
      int         g;

      //          req     thr        ret   dest    rthr   stall   cnt   cq    err
      tbl[0] = '{3'b111, 6'b111001, 1'b0, 3'b100, 2'd3, 3'b011, 3'd1, 1'b1, 1'b0};
      tbl[1] = '{3'b001, 6'b000001, 1'b0, 3'b001, 2'd1, 3'b000, 3'd0, 1'b1, 1'b0};
      tbl[2] = '{3'b001, 6'b000001, 1'b0, 3'b000, 2'd0, 3'b001, 3'd0, 1'b0, 1'b0};
      tbl[3] = '{3'b001, 6'b000001, 1'b1, 3'b000, 2'd0, 3'b001, 3'd1, 1'b0, 1'b0};
      tbl[4] = '{3'b001, 6'b000001, 1'b0, 3'b001, 2'd1, 3'b000, 3'd0, 1'b1, 1'b0};
      tbl[5] = '{3'b000, 6'b000000, 1'b1, 3'b000, 2'd0, 3'b000, 3'd1, 1'b0, 1'b0};
      tbl[6] = '{3'b100, 6'b100000, 1'b1, 3'b100, 2'd2, 3'b000, 3'd1, 1'b1, 1'b0};
      tbl[7] = '{3'b000, 6'b000000, 1'b1, 3'b000, 2'd0, 3'b000, 3'd2, 1'b0, 1'b0};
      tbl[8] = '{3'b000, 6'b000000, 1'b1, 3'b000, 2'd0, 3'b000, 3'd2, 1'b0, 1'b1};
      tbl[9] = '{3'b010, 6'b001100, 1'b0, 3'b010, 2'd3, 3'b000, 3'd1, 1'b1, 1'b1};

      // Reset state.
      do_reset();
      #1;
      check("reset credit_cnt", 32'(credit_cnt), 32'd2);
      check("reset fp_cpx_req_cq", 32'(fp_cpx_req_cq), 32'd0);
      check("reset credit_err", 32'(credit_err), 32'd0);
      check("reset dest_rdy", 32'(dest_rdy), 32'd0);

      // Directed table.
      for (int i = 0; i < 10; i++) begin
         set_in(tbl[i].req, tbl[i].thr, tbl[i].ret);
         #2;
         check($sformatf("vec%0d dest_rdy", i), 32'(dest_rdy), 32'(tbl[i].dest));
         check($sformatf("vec%0d req_thread", i), 32'(req_thread), 32'(tbl[i].rthr));
         check($sformatf("vec%0d stalls", i), 32'(stalls()), 32'(tbl[i].stall));
         @(posedge rclk);
         #1;
         check($sformatf("vec%0d credit_cnt", i), 32'(credit_cnt), 32'(tbl[i].cnt));
         check($sformatf("vec%0d fp_cpx_req_cq", i), 32'(fp_cpx_req_cq), 32'(tbl[i].cq));
         check($sformatf("vec%0d credit_err", i), 32'(credit_err), 32'(tbl[i].err));
      end

      // Starvation: div and add request continuously, and a credit returns
      // every cycle. Add is promoted on cycle 4, then div wins again.
      do_reset();
      set_in(3'b101, 6'b100001, 1'b1);
      for (int c = 0; c < 6; c++) begin
         #2;
         check($sformatf("starve c%0d dest_rdy", c), 32'(dest_rdy),
               (c == 4) ? 32'h1 : 32'h4);
         @(posedge rclk);
         #1;
      end
      check("starve credit_cnt", 32'(credit_cnt), 32'd2);

      // Reset with credits exhausted and ages nonzero.
      do_reset();
      set_in(3'b111, 6'b111001, 1'b0);
      @(posedge rclk);
      #1;
      @(posedge rclk);
      #1;
      check("prerst credit_cnt", 32'(credit_cnt), 32'd0);
      check("prerst fp_cpx_req_cq", 32'(fp_cpx_req_cq), 32'd1);
      arst = 1'b1;
      #1;
      check("inrst dest_rdy", 32'(dest_rdy), 32'd0);
      check("inrst fp_cpx_req_cq", 32'(fp_cpx_req_cq), 32'd0);
      check("inrst credit_cnt", 32'(credit_cnt), 32'd2);
      arst = 1'b0;
      #1;
      check("postrst dest_rdy", 32'(dest_rdy), 32'h4);
      check("postrst req_thread", 32'(req_thread), 32'd3);
      @(posedge rclk);
      #1;
      check("postrst fp_cpx_req_cq", 32'(fp_cpx_req_cq), 32'd1);
      check("postrst credit_cnt", 32'(credit_cnt), 32'd1);

      // Randomized traffic. Stalled pipes keep their request and thread.
      do_reset();
      m_age = '{0, 0, 0};
      m_cnt = CREDITS;
      m_err = 1'b0;
      hold  = 3'b000;
      r_req = 3'b000;
      r_thr = 6'b0;
      for (int c = 0; c < 400; c++) begin
         for (int p = 0; p < 3; p++) begin
            if (!hold[p]) begin
               r_req[p]         = ($urandom_range(0, 99) < 55);
               r_thr[2*p +: 2]  = 2'($urandom_range(0, 3));
            end
         end
         r_ret = ($urandom_range(0, 99) < 30);
         set_in(r_req, r_thr, r_ret);
         g        = model_pick(r_req);
         exp_dest = (g >= 0) ? 3'(1 << g) : 3'b000;
         exp_thr  = (g >= 0) ? r_thr[2*g +: 2] : 2'b00;
         #2;
         check($sformatf("rand c%0d dest_rdy", c), 32'(dest_rdy), 32'(exp_dest));
         check($sformatf("rand c%0d req_thread", c), 32'(req_thread), 32'(exp_thr));
         check($sformatf("rand c%0d stalls", c), 32'(stalls()), 32'(r_req & ~exp_dest));
         model_step(r_req, g, r_ret);
         hold = r_req & ~exp_dest;
         @(posedge rclk);
         #1;
         check($sformatf("rand c%0d credit_cnt", c), 32'(credit_cnt), 32'(m_cnt));
         check($sformatf("rand c%0d fp_cpx_req_cq", c), 32'(fp_cpx_req_cq), (g >= 0) ? 32'd1 : 32'd0);
         check($sformatf("rand c%0d credit_err", c), 32'(credit_err), 32'(m_err));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_fpu_out_arb
